// File: rtl/ws2812b_bit_serializer.sv
// ws2812b_bit_serializer
//   Serializes one 24-bit GRB pixel per valid/ready handshake onto the
//   single-wire WS2812B data line. Bits go out MSB first, each one a high
//   pulse (long for '1', short for '0') padded low to a fixed bit period.
//   A pixel accepted with latch=1 is followed by a long low hold so the
//   strip shows the frame.
//
// Ports
//   clk      project clock (timing defaults assume 64 MHz)
//   reset    asynchronous, active-high reset
//   data_in  pixel {G[23:16], R[15:8], B[7:0]}
//   valid    pixel present, taken only while ready=1
//   latch    taken with data_in: hold the line low after this pixel
//   ready    high while idle and able to accept a pixel
//   led      WS2812B data line (registered)
//
// Build option
//   WS2812B_OUT_INV_EN  when defined, led is inverted for boards with an
//                       inverting level shifter (idle/reset level 1).
//                       Timing is identical in both builds.
module ws2812b_bit_serializer #(
  parameter int T0H_CYCLES   = 26,
  parameter int T1H_CYCLES   = 51,
  parameter int BIT_CYCLES   = 80,
  parameter int LATCH_CYCLES = 19200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] data_in,
  input  logic        valid,
  input  logic        latch,
  output logic        ready,
  output logic        led
);

  // One counter serves both bit timing and the latch hold, so it is sized
  // for the longer of the two.
  localparam int CW = $clog2(LATCH_CYCLES + 1);

  localparam logic [CW-1:0] T0H_LAST   = CW'(T0H_CYCLES - 1);
  localparam logic [CW-1:0] T1H_LAST   = CW'(T1H_CYCLES - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);

`ifdef WS2812B_OUT_INV_EN
  localparam logic LED_OFF = 1'b1;
`else
  localparam logic LED_OFF = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [23:0]     shift_q, shift_d;
  logic            latch_q, latch_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic            led_q;
  logic [CW-1:0]   high_last;

  // Line level for a given FSM state, with board polarity applied.
  function automatic logic line_level(input state_t st);
    return (st == ST_HIGH) ? ~LED_OFF : LED_OFF;
  endfunction

  // Ready is decoded straight from state so it drops the cycle after accept.
  assign ready     = (state_q == ST_IDLE);
  assign led       = led_q;
  assign high_last = shift_q[23] ? T1H_LAST : T0H_LAST;

  // Stage p0: next-state decision
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    latch_d   = latch_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          shift_d   = data_in;
          latch_d   = latch;
          bit_cnt_d = 5'd23;
          cyc_cnt_d = '0;
          state_d   = ST_HIGH;
        end
      end
      ST_HIGH: begin
        cyc_cnt_d = cyc_cnt_q + 1'b1;
        if (cyc_cnt_q == high_last) begin
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cyc_cnt_q == BIT_LAST) begin
          shift_d   = {shift_q[22:0], 1'b0};
          cyc_cnt_d = '0;
          if (bit_cnt_q == 5'd0) begin
            state_d = latch_q ? ST_LATCH : ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
            state_d   = ST_HIGH;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (cyc_cnt_q == LATCH_LAST) begin
          cyc_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stage p1: registered state and line. led follows the next state so the
  // first high cycle is the one right after the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      latch_q   <= 1'b0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      led_q     <= LED_OFF;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      latch_q   <= latch_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      led_q     <= line_level(state_d);
    end
  end

endmodule

// File: tb/tb_ws2812b_bit_serializer.sv
module tb_ws2812b_bit_serializer;

  localparam int T0H   = 26;
  localparam int T1H   = 51;
  localparam int BITC  = 80;
  localparam int LATCH = 19200;
  localparam int PIX   = 24 * BITC;

`ifdef WS2812B_OUT_INV_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] data_in;
  logic        valid;
  logic        latch;
  logic        ready;
  logic        led;

  int checks = 0;
  int errors = 0;

  // Recorded samples (led normalised to non-inverted polarity) and the
  // sample index of the first cycle after each accepting edge.
  logic        led_s[$];
  logic        rdy_s[$];
  int          starts[$];
  logic [24:0] pend[$];
  bit          hold_mode = 1'b0;

  ws2812b_bit_serializer #(
    .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .BIT_CYCLES(BITC), .LATCH_CYCLES(LATCH)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid),
    .latch(latch), .ready(ready), .led(led)
  );

  always #5 clk = ~clk;

  // Reference: expected line level k cycles into a pixel of data d.
  function automatic logic exp_led(input logic [23:0] d, input int k);
    int b;
    int w;
    if (k < 0 || k >= PIX) return 1'b0;
    b = 23 - (k / BITC);
    w = k % BITC;
    return (w < (d[b] ? T1H : T0H));
  endfunction

  function automatic int wave_err(input int s, input logic [23:0] d, input int len);
    int e = 0;
    for (int k = 0; k < len; k++)
      if (s + k < led_s.size())
        if (led_s[s + k] !== exp_led(d, k)) e++;
    return e;
  endfunction

  function automatic int first_ready(input int s);
    for (int j = s; j < rdy_s.size(); j++)
      if (rdy_s[j] === 1'b1) return j - s;
    return -1;
  endfunction

  // Rebuild bits from high-pulse widths in the recorded window.
  task automatic decode(input int from, input int to, output logic [71:0] bits, output int nbits);
    int run = 0;
    bits  = '0;
    nbits = 0;
    for (int k = from; k < to && k < led_s.size(); k++) begin
      if (led_s[k] === 1'b1) run++;
      else if (run > 0) begin
        bits = {bits[70:0], (run >= (T0H + T1H) / 2)};
        nbits++;
        run = 0;
      end
    end
  endtask

  // Upstream-style driver plus recorder: offers a pending pixel whenever
  // ready is seen high, drops valid otherwise (or streams junk in hold mode).
  task automatic record(input int n);
    logic [24:0] p;
    led_s.delete(); rdy_s.delete(); starts.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      led_s.push_back(led ^ INV);
      rdy_s.push_back(ready);
      if (ready && pend.size() > 0) begin
        p = pend.pop_front();
        valid = 1'b1; data_in = p[24:1]; latch = p[0];
        starts.push_back(i + 1);
      end else if (hold_mode && !ready) begin
        valid = 1'b1; data_in = 24'($urandom); latch = 1'($urandom);
      end else begin
        valid = 1'b0;
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; valid = 1'b0; latch = 1'b0; data_in = '0;
    #3;
    checks++;
    if (led !== INV) begin errors++; $display("FAIL reset_led actual=%b required=%b", led, INV); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready actual=%b required=1", ready); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    record(20);
    checks++;
    if (led_s.find_index with (item !== 1'b0).size() != 0 || rdy_s.find_index with (item !== 1'b1).size() != 0) begin
      errors++; $display("FAIL reset_idle actual=not_idle required=idle");
    end
  endtask

  task automatic test_single_800000;
    int s, e, r, run;
    pend.push_back({24'h800000, 1'b0});
    record(PIX + 100);
    checks++;
    if (starts.size() != 1) begin errors++; $display("FAIL s800_accept actual=%0d required=1", starts.size()); return; end
    s = starts[0];
    checks++;
    if (rdy_s[s] !== 1'b0) begin errors++; $display("FAIL s800_ready_fall actual=%b required=0", rdy_s[s]); end
    run = 0;
    while (s + run < led_s.size() && led_s[s + run] === 1'b1) run++;
    checks++;
    if (run != T1H) begin errors++; $display("FAIL s800_first_high actual=%0d required=%0d", run, T1H); end
    e = wave_err(s, 24'h800000, PIX + 90);
    checks++;
    if (e != 0) begin errors++; $display("FAIL s800_wave actual=%0d_bad_cycles required=0", e); end
    r = first_ready(s);
    checks++;
    if (r != PIX) begin errors++; $display("FAIL s800_ready_rise actual=%0d required=%0d", r, PIX); end
  endtask

  task automatic test_latch_a5f00f;
    int s, e, r, nb;
    logic [71:0] bits;
    pend.push_back({24'hA5F00F, 1'b1});
    record(PIX + LATCH + 60);
    checks++;
    if (starts.size() != 1) begin errors++; $display("FAIL a5_accept actual=%0d required=1", starts.size()); return; end
    s = starts[0];
    decode(s, s + PIX + 10, bits, nb);
    checks++;
    if (nb != 24 || bits[23:0] !== 24'hA5F00F) begin
      errors++; $display("FAIL a5_decode actual=%0d_bits_%h required=24_bits_a5f00f", nb, bits[23:0]);
    end
    e = wave_err(s, 24'hA5F00F, PIX + LATCH + 50);
    checks++;
    if (e != 0) begin errors++; $display("FAIL a5_wave_hold actual=%0d_bad_cycles required=0", e); end
    r = first_ready(s);
    checks++;
    if (r != PIX + LATCH) begin errors++; $display("FAIL a5_ready_rise actual=%0d required=%0d", r, PIX + LATCH); end
  endtask

  task automatic test_valid_held;
    int s, e;
    logic [23:0] d;
    d = 24'($urandom);
    pend.push_back({d, 1'b0});
    hold_mode = 1'b1;
    record(PIX + 300);
    hold_mode = 1'b0;
    checks++;
    if (starts.size() != 1) begin errors++; $display("FAIL held_accepts actual=%0d required=1", starts.size()); return; end
    s = starts[0];
    e = wave_err(s, d, PIX + 290);
    checks++;
    if (e != 0) begin errors++; $display("FAIL held_wave actual=%0d_bad_cycles required=0 data=%h", e, d); end
    checks++;
    if (rdy_s[rdy_s.size() - 1] !== 1'b1) begin errors++; $display("FAIL held_idle_after actual=%b required=1", rdy_s[rdy_s.size() - 1]); end
  endtask

  task automatic test_back_to_back;
    logic [23:0] d[3];
    logic [71:0] bits;
    int nb, e, r, gap_bad;
    for (int k = 0; k < 3; k++) begin
      d[k] = 24'($urandom);
      pend.push_back({d[k], (k == 2)});
    end
    record(3 * (PIX + 1) + LATCH + 100);
    checks++;
    if (starts.size() != 3) begin errors++; $display("FAIL b2b_accepts actual=%0d required=3", starts.size()); return; end
    decode(starts[0], starts[2] + PIX + 10, bits, nb);
    checks++;
    if (nb != 72 || bits !== {d[0], d[1], d[2]}) begin
      errors++; $display("FAIL b2b_decode actual=%0d_bits_%h required=72_bits_%h", nb, bits, {d[0], d[1], d[2]});
    end
    gap_bad = 0;
    for (int k = 0; k < 2; k++)
      if (starts[k + 1] - starts[k] > PIX + 3) gap_bad++;
    checks++;
    if (gap_bad != 0) begin errors++; $display("FAIL b2b_gap actual=%0d required<=%0d", starts[1] - starts[0], PIX + 3); end
    e = wave_err(starts[0], d[0], starts[1] - starts[0]) + wave_err(starts[1], d[1], starts[2] - starts[1])
      + wave_err(starts[2], d[2], PIX + LATCH + 50);
    checks++;
    if (e != 0) begin errors++; $display("FAIL b2b_wave actual=%0d_bad_cycles required=0", e); end
    r = first_ready(starts[2]);
    checks++;
    if (r != PIX + LATCH) begin errors++; $display("FAIL b2b_ready_rise actual=%0d required=%0d", r, PIX + LATCH); end
  endtask

  task automatic test_patterns;
    logic [23:0] d[4];
    int e;
    d[0] = 24'h000000; d[1] = 24'hFFFFFF; d[2] = 24'($urandom); d[3] = 24'($urandom);
    for (int k = 0; k < 4; k++) pend.push_back({d[k], 1'b0});
    record(4 * (PIX + 1) + 50);
    checks++;
    if (starts.size() != 4) begin errors++; $display("FAIL pat_accepts actual=%0d required=4", starts.size()); return; end
    for (int k = 0; k < 4; k++) begin
      e = wave_err(starts[k], d[k], (k < 3) ? starts[k + 1] - starts[k] : PIX + 40);
      checks++;
      if (e != 0) begin errors++; $display("FAIL pat_wave_%0d actual=%0d_bad_cycles required=0 data=%h", k, e, d[k]); end
    end
  endtask

  task automatic test_reset_midframe;
    pend.push_back({24'($urandom), 1'b0});
    record(1 + 5 * BITC + 10);
    checks++;
    if (led_s[led_s.size() - 1] !== 1'b1) begin errors++; $display("FAIL mid_in_high actual=%b required=1", led_s[led_s.size() - 1]); end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (led !== INV || ready !== 1'b1) begin
      errors++; $display("FAIL mid_async actual=led%b_rdy%b required=led%b_rdy1", led, ready, INV);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    record(300);
    checks++;
    if (led_s.find_index with (item !== 1'b0).size() != 0 || rdy_s.find_index with (item !== 1'b1).size() != 0) begin
      errors++; $display("FAIL mid_no_pulses actual=activity required=idle");
    end
  endtask

  initial begin
    test_reset();
    test_single_800000();
    test_latch_a5f00f();
    test_valid_held();
    test_back_to_back();
    test_patterns();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
